// File: rtl/move_scheduler.sv
// Move pacing and two-player round-robin arbitration for the on-screen block.
// A tick divider paces moves; each tick grants one resolved direction vector as one-cycle pulses.
module move_scheduler #(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        a_up,
  input  logic        a_down,
  input  logic        a_left,
  input  logic        a_right,
  input  logic        b_up,
  input  logic        b_down,
  input  logic        b_left,
  input  logic        b_right,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic        grant_a,
  output logic        grant_b,
  output logic        tick,
  output logic [15:0] move_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_last_b;
  logic [3:0]       r_dir;
  logic             r_grant_a;
  logic             r_grant_b;
  logic [15:0]      r_move_count;

  logic [3:0] w_vec_a;
  logic [3:0] w_vec_b;
  logic       w_req_a;
  logic       w_req_b;
  logic       w_win_a;

  // Vector bit order {up, down, left, right}; opposing pairs cancel.
  function automatic logic [3:0] resolve(input logic u, input logic d,
                                         input logic l, input logic r);
    return {u & ~d, d & ~u, l & ~r, r & ~l};
  endfunction

  always_comb begin
    w_vec_a = resolve(a_up, a_down, a_left, a_right);
    w_vec_b = resolve(b_up, b_down, b_left, b_right);
    w_req_a = |w_vec_a;
    w_req_b = |w_vec_b;
    w_win_a = w_req_a && (!w_req_b || r_last_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tick       <= 1'b0;
      r_last_b     <= 1'b1;
      r_dir        <= '0;
      r_grant_a    <= 1'b0;
      r_grant_b    <= 1'b0;
      r_move_count <= '0;
    end else begin
      if (pause) begin
        r_tick <= 1'b0;
      end else if (r_cnt == CNT_W'(TICK_DIV - 1)) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
      end

      r_dir <= '0;
      // The winner's vector is loaded straight into the output register on the
      // ARB->ISSUE edge, so the pulses and grants are visible during ISSUE itself.
      unique case (r_state)
        S_IDLE: begin
          if (r_tick) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_req_a || w_req_b) begin
            r_dir        <= w_win_a ? w_vec_a : w_vec_b;
            r_grant_a    <= w_win_a;
            r_grant_b    <= !w_win_a;
            r_last_b     <= !w_win_a;
            r_move_count <= r_move_count + 16'd1;
            r_state      <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign {up, down, left, right} = r_dir;
  assign grant_a    = r_grant_a;
  assign grant_b    = r_grant_b;
  assign tick       = r_tick;
  assign move_count = r_move_count;

  a_tick_only_in_idle: assert property (@(posedge clk) disable iff (rst)
    r_tick |-> (r_state == S_IDLE));

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: directed scenarios plus random buttons/pause, checked
// every cycle against a latency-level reference model of ticks, arbitration and moves.
module tb_move_scheduler;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pause;
  logic        a_up, a_down, a_left, a_right;
  logic        b_up, b_down, b_left, b_right;
  logic        up, down, left, right;
  logic        grant_a, grant_b, tick;
  logic [15:0] move_count;

  move_scheduler #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .a_up(a_up), .a_down(a_down), .a_left(a_left), .a_right(a_right),
    .b_up(b_up), .b_down(b_down), .b_left(b_left), .b_right(b_right),
    .up(up), .down(down), .left(left), .right(right),
    .grant_a(grant_a), .grant_b(grant_b), .tick(tick), .move_count(move_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycle counts since last tick, a flag saying "this cycle
  // the tick from the previous cycle is being arbitrated", and visible outputs.
  int          m_cnt;
  bit          m_tick, m_arb_now, m_last_was_b;
  logic [3:0]  m_dir;
  bit          m_ga, m_gb;
  logic [15:0] m_moves;

  function automatic logic [3:0] net_motion(input bit u, input bit d, input bit l, input bit r);
    int v, h;
    v = int'(u) - int'(d);
    h = int'(r) - int'(l);
    return {v > 0, v < 0, h < 0, h > 0};
  endfunction

  task automatic model_edge();
    logic [3:0] va, vb;
    bit take_a;
    if (rst) begin
      m_cnt = 0; m_tick = 0; m_arb_now = 0; m_last_was_b = 1;
      m_dir = '0; m_ga = 0; m_gb = 0; m_moves = '0;
    end else begin
      va = net_motion(a_up, a_down, a_left, a_right);
      vb = net_motion(b_up, b_down, b_left, b_right);
      m_dir = '0;
      if (m_arb_now && (va != 0 || vb != 0)) begin
        take_a = (va != 0) && ((vb == 0) || m_last_was_b);
        m_dir = take_a ? va : vb;
        m_ga = take_a;
        m_gb = !take_a;
        m_last_was_b = !take_a;
        m_moves = m_moves + 16'd1;
      end
      m_arb_now = m_tick;
      if (pause) m_tick = 0;
      else if (m_cnt == TD - 1) begin m_cnt = 0; m_tick = 1; end
      else begin m_cnt++; m_tick = 0; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("dir", 32'({up, down, left, right}), 32'(m_dir));
    check("grant", 32'({grant_a, grant_b}), 32'({m_ga, m_gb}));
    check("move_count", 32'(move_count), 32'(m_moves));
  endtask

  task automatic set_btn(input logic [3:0] a, input logic [3:0] b);
    {a_up, a_down, a_left, a_right} = a;
    {b_up, b_down, b_left, b_right} = b;
  endtask

  int n;
  bit found;

  initial begin
    rst = 1; pause = 0;
    set_btn(4'b0000, 4'b0000);
    step();
    check("reset_dir", 32'({up, down, left, right}), 32'h0);
    check("reset_grants", 32'({grant_a, grant_b}), 32'h0);
    rst = 0;

    // 1: idle, tick every 4th clock
    n = 0;
    repeat (40) begin step(); if (tick) n++; end
    check("idle_tick_count", 32'(n), 32'd10);
    check("idle_moves", 32'(move_count), 32'd0);

    // 2: a_right held
    set_btn(4'b0001, 4'b0000);
    repeat (20) step();
    check("a_right_grant_a", 32'(grant_a), 32'd1);

    // 3: tie, strict alternation
    set_btn(4'b1000, 4'b0010);
    repeat (24) step();

    // 4: cancelling pairs
    set_btn(4'b1110, 4'b0000);
    repeat (16) step();
    set_btn(4'b1100, 4'b0001);
    repeat (16) step();
    set_btn(4'b1100, 4'b0000);
    repeat (12) step();

    // 5: pause mid-count, then pause raised in the ARB cycle
    set_btn(4'b0100, 4'b0000);
    repeat (2) step();
    pause = 1;
    n = 0;
    repeat (12) begin step(); if (tick) n++; end
    check("paused_ticks", 32'(n), 32'd0);
    pause = 0;
    repeat (10) step();
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin step(); found = tick; end
    check("tick_before_arb_pause", 32'(found), 32'd1);
    n = int'(move_count);
    pause = 1;
    repeat (4) step();
    check("issue_despite_pause", 32'(move_count), 32'(n + 1));
    pause = 0;

    // 6: reset during ISSUE, then tie resolves to A
    set_btn(4'b0010, 4'b0000);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin step(); found = ({up, down, left, right} != 0); end
    check("found_issue", 32'(found), 32'd1);
    rst = 1;
    step();
    check("rst_issue_dir", 32'({up, down, left, right}), 32'h0);
    check("rst_issue_count", 32'(move_count), 32'h0);
    rst = 0;
    set_btn(4'b1000, 4'b0010);
    repeat (7) step();
    check("post_rst_first_a", 32'({grant_a, grant_b}), 32'b10);

    // wrap of move_count from preloaded 0xFFFF
    set_btn(4'b0000, 4'b0000);
    repeat (3) step();
    force dut.r_move_count = 16'hFFFF;
    m_moves = 16'hFFFF;
    step();
    release dut.r_move_count;
    set_btn(4'b0001, 4'b0000);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin step(); found = right; end
    check("wrap_found_move", 32'(found), 32'd1);
    check("wrap_count", 32'(move_count), 32'h0);

    // random stimulus
    repeat (600) begin
      set_btn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      pause = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0; pause = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
